// File: rtl/networkadapter_wb_decode_pkg.sv
// Shared definitions for the network adapter Wishbone decoder: region
// codes, FSM state encoding and the region-to-target-enable helper.
package networkadapter_wb_decode_pkg;

    localparam logic [1:0] NA_REGION_CONF     = 2'd0;
    localparam logic [1:0] NA_REGION_MPSIMPLE = 2'd1;
    localparam logic [1:0] NA_REGION_DMA      = 2'd2;
    localparam logic [1:0] NA_REGION_NONE     = 2'd3;

    typedef enum logic [2:0] {
        NA_WBDEC_IDLE  = 3'd0,
        NA_WBDEC_ISSUE = 3'd1,
        NA_WBDEC_WAIT  = 3'd2,
        NA_WBDEC_RESP  = 3'd3,
        NA_WBDEC_DRAIN = 3'd4
    } na_wbdec_state_t;

    // One-hot target select for a region; the unmapped region selects nothing.
    function automatic logic [2:0] na_region_onehot(input logic [1:0] region);
        logic [2:0] oh;
        case (region)
            NA_REGION_CONF:     oh = 3'b001;
            NA_REGION_MPSIMPLE: oh = 3'b010;
            NA_REGION_DMA:      oh = 3'b100;
            default:            oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/networkadapter_wb.sv
// This file intentionally contains no design units.

// File: rtl/networkadapter_wb_timeout.sv
// Response watchdog: counts enabled cycles after a clear and flags the
// cycle in which the TIMEOUT-th enabled cycle is reached.
module networkadapter_wb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise advance while enabled, saturating at LAST.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // The current enabled cycle is the TIMEOUT-th one since the clear.
    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/networkadapter_wb_decode.sv
// Wishbone-classic slave front end of the compute-tile network adapter.
// Decodes the 16-bit NA window into conf / mp_simple / dma, issues a
// single-cycle request to the selected target and relays its response.
module networkadapter_wb_decode
    import networkadapter_wb_decode_pkg::*;
#(
    parameter int ENABLE_MPSIMPLE = 1,
    parameter int ENABLE_DMA      = 1,
    parameter int TIMEOUT         = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             wb_rty_o,
    output logic [15:0]      t_adr,
    output logic             t_we,
    output logic [31:0]      t_dat_o,
    output logic [2:0]       t_en,
    input  logic [2:0][31:0] t_dat_i,
    input  logic [2:0]       t_ack,
    input  logic [2:0]       t_err,
    input  logic [2:0]       t_rty
);

    na_wbdec_state_t state_q, state_d;
    logic [1:0]  region_q;
    logic [15:0] t_adr_q;
    logic        t_we_q;
    logic [31:0] t_dat_q;
    logic [2:0]  t_en_q, t_en_d;
    logic        ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic [31:0] wb_dat_q, dat_d;

    logic        latch_s, tmr_clr_s, tmr_en_s, tmr_expired_s;
    logic        region_ok_s;
    logic [2:0]  sel_oh_s;
    logic        sel_ack_s, sel_err_s, sel_rty_s, resp_any_s;
    logic [31:0] rdata_s;
    logic        unused_adr_s;

    // Address bits above the NA window are not decoded.
    assign unused_adr_s = ^wb_adr_i[31:16];

    networkadapter_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmr_clr_s),
        .en_i      (tmr_en_s),
        .expired_o (tmr_expired_s)
    );

    // Only the strobes of the target we actually addressed are considered.
    assign sel_oh_s   = na_region_onehot(region_q);
    assign sel_ack_s  = |(t_ack & sel_oh_s);
    assign sel_err_s  = |(t_err & sel_oh_s);
    assign sel_rty_s  = |(t_rty & sel_oh_s);
    assign resp_any_s = sel_ack_s | sel_err_s | sel_rty_s;

    // Region decode of the incoming address, honouring disabled targets.
    always_comb begin
        region_ok_s = 1'b0;
        case (wb_adr_i[15:14])
            NA_REGION_CONF:     region_ok_s = 1'b1;
            NA_REGION_MPSIMPLE: region_ok_s = (ENABLE_MPSIMPLE != 0);
            NA_REGION_DMA:      region_ok_s = (ENABLE_DMA != 0);
            default:            region_ok_s = 1'b0;
        endcase
    end

    // Read data mux from the selected target.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (region_q)
            NA_REGION_CONF:     rdata_s = t_dat_i[0];
            NA_REGION_MPSIMPLE: rdata_s = t_dat_i[1];
            NA_REGION_DMA:      rdata_s = t_dat_i[2];
            default:            rdata_s = 32'h0000_0000;
        endcase
    end

    // Next-state and next-output logic of the access FSM.
    always_comb begin
        state_d   = state_q;
        t_en_d    = 3'b000;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rty_d     = 1'b0;
        dat_d     = wb_dat_q;
        latch_s   = 1'b0;
        tmr_clr_s = 1'b0;
        tmr_en_s  = 1'b0;
        case (state_q)
            NA_WBDEC_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    latch_s = 1'b1;
                    if (region_ok_s) begin
                        state_d = NA_WBDEC_ISSUE;
                        t_en_d  = na_region_onehot(wb_adr_i[15:14]);
                    end else begin
                        state_d = NA_WBDEC_RESP;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = NA_WBDEC_IDLE;
                end
            end
            NA_WBDEC_ISSUE: begin
                tmr_clr_s = 1'b1;
                if (!wb_cyc_i) begin
                    state_d = NA_WBDEC_DRAIN;
                end else begin
                    state_d = NA_WBDEC_WAIT;
                end
            end
            NA_WBDEC_WAIT: begin
                tmr_en_s = 1'b1;
                if (!wb_cyc_i) begin
                    // Abort: a response already present is simply consumed.
                    if (resp_any_s || tmr_expired_s) begin
                        state_d = NA_WBDEC_IDLE;
                    end else begin
                        state_d = NA_WBDEC_DRAIN;
                    end
                end else if (sel_err_s) begin
                    state_d = NA_WBDEC_RESP;
                    err_d   = 1'b1;
                end else if (sel_rty_s) begin
                    state_d = NA_WBDEC_RESP;
                    rty_d   = 1'b1;
                end else if (sel_ack_s) begin
                    state_d = NA_WBDEC_RESP;
                    ack_d   = 1'b1;
                    if (!t_we_q) begin
                        dat_d = rdata_s;
                    end else begin
                        dat_d = wb_dat_q;
                    end
                end else if (tmr_expired_s) begin
                    state_d = NA_WBDEC_RESP;
                    err_d   = 1'b1;
                end else begin
                    state_d = NA_WBDEC_WAIT;
                end
            end
            NA_WBDEC_RESP: begin
                state_d = NA_WBDEC_IDLE;
            end
            NA_WBDEC_DRAIN: begin
                tmr_en_s = 1'b1;
                if (resp_any_s || tmr_expired_s) begin
                    state_d = NA_WBDEC_IDLE;
                end else begin
                    state_d = NA_WBDEC_DRAIN;
                end
            end
            default: begin
                state_d = NA_WBDEC_IDLE;
            end
        endcase
    end

    // State, registered bus outputs and the latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= NA_WBDEC_IDLE;
            region_q <= NA_REGION_NONE;
            t_adr_q  <= 16'h0000;
            t_we_q   <= 1'b0;
            t_dat_q  <= 32'h0000_0000;
            t_en_q   <= 3'b000;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rty_q    <= 1'b0;
            wb_dat_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            t_en_q   <= t_en_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rty_q    <= rty_d;
            wb_dat_q <= dat_d;
            if (latch_s) begin
                region_q <= wb_adr_i[15:14];
                t_adr_q  <= {2'b00, wb_adr_i[13:0]};
                t_we_q   <= wb_we_i;
                t_dat_q  <= wb_dat_i;
            end
        end
    end

    assign wb_dat_o = wb_dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = rty_q;
    assign t_adr    = t_adr_q;
    assign t_we     = t_we_q;
    assign t_dat_o  = t_dat_q;
    assign t_en     = t_en_q;

endmodule
